// File: rtl/execute_stage.sv
// EX stage of the 5-stage RV32I pipeline: forwarding muxes, ALU,
// branch compare, PC-target adder and the EX/MEM pipeline register.
module execute_stage #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            validE,
  input  logic            regwriteE,
  input  logic            memwriteE,
  input  logic [1:0]      resultsrcE,
  input  logic            branchE,
  input  logic            jumpE,
  input  logic            jalrE,
  input  logic            alusrcE,
  input  logic [3:0]      alucontrolE,
  input  logic [2:0]      funct3E,
  input  logic [XLEN-1:0] rd1E,
  input  logic [XLEN-1:0] rd2E,
  input  logic [XLEN-1:0] pcE,
  input  logic [XLEN-1:0] pcplus4E,
  input  logic [XLEN-1:0] immextE,
  input  logic [4:0]      rdE,
  input  logic [1:0]      forwardAE,
  input  logic [1:0]      forwardBE,
  input  logic [XLEN-1:0] resultW,
  output logic            pcsrcE,
  output logic [XLEN-1:0] pctargetE,
  output logic            validM,
  output logic            regwriteM,
  output logic            memwriteM,
  output logic [1:0]      resultsrcM,
  output logic [4:0]      rdM,
  output logic [XLEN-1:0] aluresultM,
  output logic [XLEN-1:0] writedataM,
  output logic [XLEN-1:0] pcplus4M
);

  logic [XLEN-1:0] fwdA, fwdB, srcB;
  logic [XLEN-1:0] alu_res;
  logic [XLEN-1:0] jalr_sum;
  logic [4:0]      shamt;
  logic            lt_s, lt_u, eq;
  logic            cond;

  logic            valid_q, regwrite_q, memwrite_q;
  logic [1:0]      resultsrc_q;
  logic [4:0]      rd_q;
  logic [XLEN-1:0] alu_q, wdata_q, pc4_q;

  always_comb begin
    case (forwardAE)
      2'b01:   fwdA = resultW;
      2'b10:   fwdA = alu_q;
      default: fwdA = rd1E;
    endcase
    case (forwardBE)
      2'b01:   fwdB = resultW;
      2'b10:   fwdB = alu_q;
      default: fwdB = rd2E;
    endcase
  end

  assign srcB  = alusrcE ? immextE : fwdB;
  assign shamt = srcB[4:0];

  always_comb begin
    alu_res = '0;
    case (alucontrolE)
      4'b0000: alu_res = fwdA + srcB;
      4'b0001: alu_res = fwdA - srcB;
      4'b0010: alu_res = fwdA & srcB;
      4'b0011: alu_res = fwdA | srcB;
      4'b0100: alu_res = fwdA ^ srcB;
      4'b0101: alu_res = {{(XLEN-1){1'b0}},
                          $signed(fwdA) < $signed(srcB)};
      4'b0110: alu_res = {{(XLEN-1){1'b0}}, fwdA < srcB};
      4'b0111: alu_res = fwdA << shamt;
      4'b1000: alu_res = fwdA >> shamt;
      4'b1001: alu_res = $unsigned($signed(fwdA) >>> shamt);
      4'b1010: alu_res = srcB;
      default: alu_res = '0;
    endcase
  end

  // Branch compare always uses rs2, never the immediate path.
  assign eq   = (fwdA == fwdB);
  assign lt_s = ($signed(fwdA) < $signed(fwdB));
  assign lt_u = (fwdA < fwdB);

  always_comb begin
    cond = 1'b0;
    case (funct3E)
      3'b000:  cond = eq;
      3'b001:  cond = ~eq;
      3'b100:  cond = lt_s;
      3'b101:  cond = ~lt_s;
      3'b110:  cond = lt_u;
      3'b111:  cond = ~lt_u;
      default: cond = 1'b0;
    endcase
  end

  assign jalr_sum  = fwdA + immextE;
  assign pctargetE = jalrE ? {jalr_sum[XLEN-1:1], 1'b0}
                           : pcE + immextE;
  assign pcsrcE    = validE & ~rst & (jumpE | (branchE & cond));

  // rdM is cleared too, so the forwarding unit never matches stale state.
  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= 1'b0;
      regwrite_q  <= 1'b0;
      memwrite_q  <= 1'b0;
      resultsrc_q <= '0;
      rd_q        <= '0;
      alu_q       <= '0;
      wdata_q     <= '0;
      pc4_q       <= '0;
    end else begin
      valid_q     <= validE;
      regwrite_q  <= validE & regwriteE;
      memwrite_q  <= validE & memwriteE;
      resultsrc_q <= resultsrcE;
      rd_q        <= rdE;
      alu_q       <= alu_res;
      wdata_q     <= fwdB;
      pc4_q       <= pcplus4E;
    end
  end

  assign validM     = valid_q;
  assign regwriteM  = regwrite_q;
  assign memwriteM  = memwrite_q;
  assign resultsrcM = resultsrc_q;
  assign rdM        = rd_q;
  assign aluresultM = alu_q;
  assign writedataM = wdata_q;
  assign pcplus4M   = pc4_q;

endmodule

// File: tb/tb_execute_stage.sv
// Directed and random checks of execute_stage against an
// arithmetic reference model of the EX stage.
module tb_execute_stage;

  logic        clk = 1'b0;
  logic        rst;
  logic        validE, regwriteE, memwriteE;
  logic [1:0]  resultsrcE;
  logic        branchE, jumpE, jalrE, alusrcE;
  logic [3:0]  alucontrolE;
  logic [2:0]  funct3E;
  logic [31:0] rd1E, rd2E, pcE, pcplus4E, immextE, resultW;
  logic [4:0]  rdE;
  logic [1:0]  forwardAE, forwardBE;
  logic        pcsrcE;
  logic [31:0] pctargetE;
  logic        validM, regwriteM, memwriteM;
  logic [1:0]  resultsrcM;
  logic [4:0]  rdM;
  logic [31:0] aluresultM, writedataM, pcplus4M;

  int vectors = 0;
  int miscompares = 0;

  // model of the EX/MEM register contents
  logic        m_valid, m_rw, m_mw;
  logic [1:0]  m_rs;
  logic [4:0]  m_rd;
  logic [31:0] m_alu, m_wd, m_pc4;

  always #5 clk = ~clk;

  execute_stage #(.XLEN(32)) dut (
    .clk(clk), .rst(rst), .validE(validE),
    .regwriteE(regwriteE), .memwriteE(memwriteE),
    .resultsrcE(resultsrcE), .branchE(branchE),
    .jumpE(jumpE), .jalrE(jalrE), .alusrcE(alusrcE),
    .alucontrolE(alucontrolE), .funct3E(funct3E),
    .rd1E(rd1E), .rd2E(rd2E), .pcE(pcE),
    .pcplus4E(pcplus4E), .immextE(immextE), .rdE(rdE),
    .forwardAE(forwardAE), .forwardBE(forwardBE),
    .resultW(resultW), .pcsrcE(pcsrcE),
    .pctargetE(pctargetE), .validM(validM),
    .regwriteM(regwriteM), .memwriteM(memwriteM),
    .resultsrcM(resultsrcM), .rdM(rdM),
    .aluresultM(aluresultM), .writedataM(writedataM),
    .pcplus4M(pcplus4M)
  );

  function automatic logic [31:0] pick(input logic [1:0] sel,
                                       input logic [31:0] rf);
    if (sel == 2'b01) return resultW;
    if (sel == 2'b10) return m_alu;
    return rf;
  endfunction

  // signed order = unsigned order with the sign bits flipped
  function automatic bit slt(input logic [31:0] a, input logic [31:0] b);
    return (a ^ 32'h8000_0000) < (b ^ 32'h8000_0000);
  endfunction

  function automatic logic [31:0] ref_alu(input logic [3:0] op,
                                          input logic [31:0] a,
                                          input logic [31:0] b);
    int s;
    logic [31:0] ones;
    s = int'(b % 32);
    ones = 32'hFFFF_FFFF;
    case (op)
      4'd0:  return a + b;
      4'd1:  return a + ~b + 32'd1;
      4'd2:  return a & b;
      4'd3:  return a | b;
      4'd4:  return a ^ b;
      4'd5:  return {31'd0, slt(a, b)};
      4'd6:  return {31'd0, a < b};
      4'd7:  return a * (32'd1 << s);
      4'd8:  return a / (32'd1 << s);
      4'd9:  return (a / (32'd1 << s)) |
                    (a[31] ? ~(ones / (32'd1 << s)) : 32'd0);
      4'd10: return b;
      default: return 32'd0;
    endcase
  endfunction

  function automatic bit ref_br(input logic [2:0] f,
                                input logic [31:0] a,
                                input logic [31:0] b);
    case (f)
      3'd0: return a == b;
      3'd1: return a != b;
      3'd4: return slt(a, b);
      3'd5: return !slt(a, b);
      3'd6: return a < b;
      3'd7: return !(a < b);
      default: return 1'b0;
    endcase
  endfunction

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr();
    rst = 0; validE = 1; regwriteE = 0; memwriteE = 0;
    resultsrcE = 0; branchE = 0; jumpE = 0; jalrE = 0;
    alusrcE = 0; alucontrolE = 0; funct3E = 3'd2;
    rd1E = 0; rd2E = 0; pcE = 0; pcplus4E = 0; immextE = 0;
    rdE = 0; forwardAE = 0; forwardBE = 0; resultW = 0;
  endtask

  // one instruction: check redirect, clock, check EX/MEM contents
  task automatic cycle();
    logic [31:0] fa, fb, res, tgt;
    bit pcs;
    fa  = pick(forwardAE, rd1E);
    fb  = pick(forwardBE, rd2E);
    res = ref_alu(alucontrolE, fa, alusrcE ? immextE : fb);
    tgt = jalrE ? ((fa + immextE) & 32'hFFFF_FFFE) : pcE + immextE;
    pcs = validE && !rst &&
          (jumpE || (branchE && ref_br(funct3E, fa, fb)));
    #1;
    check("pcsrcE", {31'd0, pcsrcE}, {31'd0, pcs});
    check("pctargetE", pctargetE, tgt);
    @(posedge clk);
    #1;
    if (rst) begin
      m_valid = 0; m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0;
      m_alu = 0; m_wd = 0; m_pc4 = 0;
    end else begin
      m_valid = validE; m_rw = validE && regwriteE;
      m_mw = validE && memwriteE; m_rs = resultsrcE; m_rd = rdE;
      m_alu = res; m_wd = fb; m_pc4 = pcplus4E;
    end
    check("validM", {31'd0, validM}, {31'd0, m_valid});
    check("regwriteM", {31'd0, regwriteM}, {31'd0, m_rw});
    check("memwriteM", {31'd0, memwriteM}, {31'd0, m_mw});
    if (m_valid || rst) begin
      check("resultsrcM", {30'd0, resultsrcM}, {30'd0, m_rs});
      check("rdM", {27'd0, rdM}, {27'd0, m_rd});
      check("aluresultM", aluresultM, m_alu);
      check("writedataM", writedataM, m_wd);
      check("pcplus4M", pcplus4M, m_pc4);
    end
  endtask

  initial begin
    m_valid = 0; m_rw = 0; m_mw = 0; m_rs = 0; m_rd = 0;
    m_alu = 0; m_wd = 0; m_pc4 = 0;
    clr();
    validE = 0;
    rst = 1;
    rdE = 5'd7; rd1E = 32'h55;
    cycle();
    check("reset_rdM", {27'd0, rdM}, 32'd0);

    // forward priority
    clr(); alusrcE = 1; immextE = 3; rd1E = 2;
    cycle();
    rd1E = 1; resultW = 9; forwardAE = 2'b10;
    cycle();
    check("fwd_alu", aluresultM, 32'd8);
    forwardAE = 2'b01;
    cycle();
    check("fwd_wb", aluresultM, 32'd12);
    forwardAE = 2'b00;
    cycle();
    check("fwd_rf", aluresultM, 32'd4);

    // ALU edges
    clr(); alusrcE = 1; rd1E = 32'h8000_0000; immextE = 1;
    alucontrolE = 4'd5; cycle();
    check("slt", aluresultM, 32'd1);
    alucontrolE = 4'd6; cycle();
    check("sltu", aluresultM, 32'd0);
    immextE = 31; alucontrolE = 4'd9; cycle();
    check("sra31", aluresultM, 32'hFFFF_FFFF);
    alucontrolE = 4'd8; cycle();
    check("srl31", aluresultM, 32'd1);
    rd1E = 32'hFFFF_FFFF; immextE = 1; alucontrolE = 4'd0; cycle();
    check("add_wrap", aluresultM, 32'd0);
    rd1E = 32'h1234; alucontrolE = 4'hF; cycle();
    check("op_1111", aluresultM, 32'd0);

    // branch: BLT taken, BLTU not taken
    clr(); branchE = 1; funct3E = 3'd4; rd1E = 32'hFFFF_FFFF;
    rd2E = 1; pcE = 32'h100; immextE = 32'hFFFF_FFF8;
    #1;
    check("blt_pcsrc", {31'd0, pcsrcE}, 32'd1);
    check("blt_target", pctargetE, 32'hF8);
    cycle();
    funct3E = 3'd6;
    cycle();

    // JALR link
    clr(); jumpE = 1; jalrE = 1; regwriteE = 1; rdE = 5'd1;
    rd1E = 32'h1003; immextE = 4; pcE = 32'h200;
    pcplus4E = 32'h204; alucontrolE = 4'd0;
    #1;
    check("jalr_target", pctargetE, 32'h1006);
    cycle();
    check("jalr_pc4", pcplus4M, 32'h204);

    // bubble with a true branch
    clr(); validE = 0; regwriteE = 1; memwriteE = 1; branchE = 1;
    funct3E = 3'd0;
    cycle();

    // reset mid-stream over an in-flight store
    clr(); memwriteE = 1; rdE = 5'd9; rd1E = 32'h40; rd2E = 32'hAB;
    alusrcE = 1; immextE = 8;
    cycle();
    rst = 1; jumpE = 1;
    cycle();
    check("rst_alu", aluresultM, 32'd0);
    rst = 0; jumpE = 0; regwriteE = 1; memwriteE = 0;
    cycle();

    // random traffic
    for (int i = 0; i < 400; i++) begin
      rst         = ($urandom_range(0, 49) == 0);
      validE      = ($urandom_range(0, 4) != 0);
      regwriteE   = 1'($urandom);
      memwriteE   = 1'($urandom);
      resultsrcE  = 2'($urandom);
      branchE     = 1'($urandom);
      jumpE       = ($urandom_range(0, 5) == 0);
      jalrE       = 1'($urandom);
      alusrcE     = 1'($urandom);
      alucontrolE = 4'($urandom);
      funct3E     = 3'($urandom);
      rd1E        = $urandom;
      rd2E        = ($urandom_range(0, 3) == 0) ? rd1E : $urandom;
      pcE         = $urandom & 32'hFFFF_FFFC;
      pcplus4E    = pcE + 4;
      immextE     = $urandom_range(0, 1) ? $urandom
                                         : 32'($urandom_range(0, 40));
      rdE         = 5'($urandom);
      forwardAE   = 2'($urandom);
      forwardBE   = 2'($urandom);
      resultW     = $urandom;
      if (!m_valid && forwardAE == 2'b10) forwardAE = 2'b00;
      if (!m_valid && forwardBE == 2'b10) forwardBE = 2'b00;
      cycle();
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
